accum_prod_to_posit16: RTL



---
 rtl/posit_defines_pkg.sv | 36 +++
 rtl/shift_right.sv | 20 ++
 rtl/accum_prod_to_posit16.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/posit_defines_pkg.sv
// Shared posit constants and the decoded-accumulator bundle used by the
// accumulator-to-posit16 output converter.
package posit_defines;

  localparam int unsigned FBITS_ACCUM                          = 32;
  localparam int unsigned POSIT_SERIALIZED_WIDTH_ACCUM_PROD_ES2 = FBITS_ACCUM + 12;

  localparam int unsigned POSIT16_W      = 16;
  localparam int unsigned SCALE_W        = 9;
  localparam int unsigned REGIME_SHIFT_W = 5;

  localparam logic [POSIT16_W-1:0] POSIT16_ES2_MAXPOS = 16'h7FFF;
  localparam logic [POSIT16_W-1:0] POSIT16_ES2_MINPOS = 16'h0001;
  localparam logic [POSIT16_W-1:0] POSIT16_ES2_NAR    = 16'h8000;
  localparam int                   POSIT16_ES2_MAX_SCALE = 56;

  typedef enum logic [2:0] {
    CLS_REG    = 3'd0,
    CLS_NAR    = 3'd1,
    CLS_ZERO   = 3'd2,
    CLS_SAT_HI = 3'd3,
    CLS_SAT_LO = 3'd4
  } val_class_e;

  // Stage-1 decoded bundle: classification plus regime-shift parameters.
  typedef struct packed {
    val_class_e                cls;
    logic                      sgn;
    logic [REGIME_SHIFT_W-1:0] m;
    logic                      rfill;
    logic [1:0]                e;
    logic [FBITS_ACCUM-1:0]    fraction;
    logic                      trunc;
  } accum_dec_t;

endpackage

// File: rtl/shift_right.sv
// Logical right shift with a selectable fill bit; also reports whether any
// set bit was shifted out of the bottom.
module shift_right #(
  parameter int unsigned N = 36,
  parameter int unsigned S = 5
) (
  input  logic [N-1:0] din,
  input  logic [S-1:0] shamt,
  input  logic         fill,
  output logic [N-1:0] dout,
  output logic         sticky
);

  logic [N-1:0] lost_mask;

  assign dout      = N'({{N{fill}}, din} >> shamt);
  assign lost_mask = (N'(1) << shamt) - N'(1);
  assign sticky    = |(din & lost_mask);

endmodule

// File: rtl/accum_prod_to_posit16.sv
// Three-stage converter from the serialized product-accumulator value to a
// rounded posit16 (es=2): decode, regime shift, round/negate.
module accum_prod_to_posit16 #(
  parameter int unsigned FBITS_ACCUM = posit_defines::FBITS_ACCUM,
  parameter int unsigned IN_W        = FBITS_ACCUM + 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [IN_W-1:0] in_value,
  input  logic            in_trunc,
  output logic            out_valid,
  output logic [15:0]     out_posit,
  output logic            out_inexact,
  output logic            out_nar
);

  import posit_defines::*;

  localparam int unsigned SH_N   = FBITS_ACCUM + 4;
  localparam int unsigned BODY_W = 15;
  localparam logic signed [SCALE_W-1:0] MAX_SCALE = SCALE_W'(POSIT16_ES2_MAX_SCALE);
  localparam logic signed [SCALE_W-1:0] MIN_SCALE = SCALE_W'(-POSIT16_ES2_MAX_SCALE);

  // Field extraction: {sgn, scale, fraction, inf, zero}
  logic                      in_sgn;
  logic signed [SCALE_W-1:0] in_scale;
  logic [FBITS_ACCUM-1:0]    in_frac;
  logic                      in_inf;
  logic                      in_zero;

  assign in_sgn   = in_value[IN_W-1];
  assign in_scale = in_value[IN_W-2 -: SCALE_W];
  assign in_frac  = in_value[FBITS_ACCUM+1:2];
  assign in_inf   = in_value[1];
  assign in_zero  = in_value[0];

  accum_dec_t dec;
  logic       dec_sat_inexact;

  // Classify and derive regime shift; k[4:0] == scale[6:2] in the regular range.
  always_comb begin
    dec             = '0;
    dec_sat_inexact = 1'b1;
    dec.sgn         = in_sgn;
    dec.rfill       = ~in_scale[SCALE_W-1];
    dec.e           = in_scale[1:0];
    dec.fraction    = in_frac;
    dec.trunc       = in_trunc;
    dec.m           = dec.rfill ? in_scale[6:2] : ~in_scale[6:2];
    if (in_inf) begin
      dec.cls = CLS_NAR;
    end else if (in_zero) begin
      dec.cls = CLS_ZERO;
    end else if (in_scale >= MAX_SCALE) begin
      dec.cls         = CLS_SAT_HI;
      dec_sat_inexact = !((in_scale == MAX_SCALE) && (in_frac == '0) && !in_trunc);
    end else if (in_scale < MIN_SCALE) begin
      dec.cls = CLS_SAT_LO;
    end else begin
      dec.cls = CLS_REG;
    end
  end

  logic       s1_valid;
  accum_dec_t s1;
  logic       s1_sat_inexact;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid       <= 1'b0;
      s1             <= '0;
      s1_sat_inexact <= 1'b0;
    end else begin
      if (in_valid) begin
        s1_valid       <= 1'b1;
        s1             <= dec;
        s1_sat_inexact <= dec_sat_inexact;
      end else begin
        s1_valid <= 1'b0;
      end
    end
  end

  logic [SH_N-1:0] regime_str;
  logic [SH_N-1:0] shifted;
  logic            shift_sticky;

  assign regime_str = {s1.rfill, ~s1.rfill, s1.e, s1.fraction};

  shift_right #(
    .N(SH_N),
    .S(REGIME_SHIFT_W)
  ) u_regime_shift (
    .din   (regime_str),
    .shamt (s1.m),
    .fill  (s1.rfill),
    .dout  (shifted),
    .sticky(shift_sticky)
  );

  logic              s2_valid;
  val_class_e        s2_cls;
  logic              s2_sgn;
  logic              s2_trunc;
  logic              s2_sat_inexact;
  logic [BODY_W-1:0] s2_p;
  logic              s2_g;
  logic              s2_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid       <= 1'b0;
      s2_cls         <= CLS_REG;
      s2_sgn         <= 1'b0;
      s2_trunc       <= 1'b0;
      s2_sat_inexact <= 1'b0;
      s2_p           <= '0;
      s2_g           <= 1'b0;
      s2_s           <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_cls         <= s1.cls;
        s2_sgn         <= s1.sgn;
        s2_trunc       <= s1.trunc;
        s2_sat_inexact <= s1_sat_inexact;
        s2_p           <= shifted[SH_N-1 -: BODY_W];
        s2_g           <= shifted[SH_N-BODY_W-1];
        s2_s           <= (|shifted[SH_N-BODY_W-2:0]) | shift_sticky | s1.trunc;
      end
    end
  end

  logic        round_up;
  logic [15:0] mag;
  logic        negate;
  logic [15:0] res_posit;
  logic        res_inexact;
  logic        res_nar;

  assign round_up = s2_g & (s2_p[0] | s2_s);

  // Round to nearest even, then apply specials and sign.
  always_comb begin
    mag         = {1'b0, s2_p} + 16'(round_up);
    res_inexact = s2_g | s2_s;
    res_nar     = 1'b0;
    negate      = s2_sgn;
    case (s2_cls)
      CLS_NAR: begin
        mag         = POSIT16_ES2_NAR;
        res_inexact = 1'b0;
        res_nar     = 1'b1;
        negate      = 1'b0;
      end
      CLS_ZERO: begin
        mag         = '0;
        res_inexact = s2_trunc;
        negate      = 1'b0;
      end
      CLS_SAT_HI: begin
        mag         = POSIT16_ES2_MAXPOS;
        res_inexact = s2_sat_inexact;
      end
      CLS_SAT_LO: begin
        mag         = POSIT16_ES2_MINPOS;
        res_inexact = 1'b1;
      end
      default: ;
    endcase
    res_posit = negate ? (~mag + 16'd1) : mag;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_posit   <= '0;
      out_inexact <= 1'b0;
      out_nar     <= 1'b0;
    end else begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_posit   <= res_posit;
        out_inexact <= res_inexact;
        out_nar     <= res_nar;
      end
    end
  end

endmodule
